// File: rtl/card_deal_generator.sv
// card_deal_generator: deals 2*N_PAIRS palette-coloured cards in a random order
// and writes them to the card register file.
// The order comes from a Fisher-Yates shuffle driven by a free-running LFSR.
// Ports:
//   clk, rst       clock; asynchronous active-low reset
//   start          deal request, honoured only while idle
//   busy           high in every state except idle
//   done           one-cycle pulse after the last card write is accepted
//   wr_en/wr_ready write valid/ready handshake toward the regfile
//   wr_addr        BASE_ADDR + slot index
//   wr_data        {RGB444 colour, discovered=0, active=1}
module card_deal_generator #(
   parameter int unsigned N_PAIRS   = 6,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned BASE_ADDR = 1,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              wr_en,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [13:0]       wr_data
);

   localparam int unsigned N_CARDS = 2 * N_PAIRS;
   localparam int unsigned SLOTS   = 16;
   localparam int unsigned IDX_W   = 4;
   localparam logic [15:0] TAPS    = 16'hB400;

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_SHUFFLE, S_WRITE, S_DONE} state_t;

   state_t            state, state_n;
   logic [15:0]       lfsr, lfsr_n;
   logic [2:0]        perm   [SLOTS];
   logic [2:0]        perm_n [SLOTS];
   logic [IDX_W-1:0]  idx, idx_n, r;
   logic              busy_n, done_n, wr_en_n;
   logic [ADDR_W-1:0] wr_addr_n;
   logic [13:0]       wr_data_n;

   // Smallest all-ones mask covering i, keeps the rejection rate below one half.
   function automatic logic [IDX_W-1:0] mask_of(input logic [IDX_W-1:0] i);
      if (i <= IDX_W'(1))      return IDX_W'(1);
      else if (i <= IDX_W'(3)) return IDX_W'(3);
      else if (i <= IDX_W'(7)) return IDX_W'(7);
      else                     return IDX_W'(15);
   endfunction

   function automatic logic [11:0] palette(input logic [2:0] p);
      case (p)
         3'd0:    return 12'hF00;
         3'd1:    return 12'h0F0;
         3'd2:    return 12'h00F;
         3'd3:    return 12'h0FF;
         3'd4:    return 12'hF0F;
         3'd5:    return 12'hFF0;
         3'd6:    return 12'hFFF;
         default: return 12'h0AA;
      endcase
   endfunction

   assign r = lfsr[IDX_W-1:0] & mask_of(idx);

   // Next state, slot array and registered-output values.
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      perm_n    = perm;
      lfsr_n    = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
      wr_addr_n = wr_addr;
      wr_data_n = wr_data;

      case (state)
         S_IDLE: begin
            if (start) state_n = S_INIT;
         end
         S_INIT: begin
            for (int k = 0; k < int'(SLOTS); k++) perm_n[k] = 3'(k >> 1);
            idx_n   = IDX_W'(N_CARDS - 1);
            state_n = S_SHUFFLE;
         end
         S_SHUFFLE: begin
            // Draws above i are rejected and retried with the next LFSR value.
            if (r <= idx) begin
               perm_n[idx] = perm[r];
               perm_n[r]   = perm[idx];
               if (idx == IDX_W'(1)) begin
                  idx_n   = '0;
                  state_n = S_WRITE;
               end else begin
                  idx_n = idx - IDX_W'(1);
               end
            end
         end
         S_WRITE: begin
            if (wr_en && wr_ready) begin
               if (idx == IDX_W'(N_CARDS - 1)) state_n = S_DONE;
               else                            idx_n   = idx + IDX_W'(1);
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase

      // Outputs are derived from the upcoming state so they register in step with it.
      wr_en_n = (state_n == S_WRITE);
      done_n  = (state_n == S_DONE);
      busy_n  = (state_n != S_IDLE);
      if (state_n == S_WRITE) begin
         wr_addr_n = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_n);
         wr_data_n = {palette(perm_n[idx_n]), 2'b01};
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         lfsr    <= LFSR_SEED;
         perm    <= '{default: '0};
         idx     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         state   <= state_n;
         lfsr    <= lfsr_n;
         perm    <= perm_n;
         idx     <= idx_n;
         busy    <= busy_n;
         done    <= done_n;
         wr_en   <= wr_en_n;
         wr_addr <= wr_addr_n;
         wr_data <= wr_data_n;
      end
   end

endmodule

// File: tb/tb_card_deal_generator.sv
// Testbench for card_deal_generator: three instances (6, 8 and 2 pairs) share
// clock, reset, start and wr_ready; a per-cycle model checks all of them.
module tb_card_deal_generator;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic ready = 1'b0;

   logic       wen6, busy6, done6;
   logic [3:0] addr6;
   logic [13:0] data6;
   logic       wen8, busy8, done8;
   logic [4:0] addr8;
   logic [13:0] data8;
   logic       wen2, busy2, done2;
   logic [3:0] addr2;
   logic [13:0] data2;

   always #5 clk = ~clk;

   card_deal_generator #(.N_PAIRS(6)) u6 (
      .clk(clk), .rst(rst), .start(start), .busy(busy6), .done(done6),
      .wr_en(wen6), .wr_ready(ready), .wr_addr(addr6), .wr_data(data6));
   card_deal_generator #(.N_PAIRS(8), .ADDR_W(5)) u8 (
      .clk(clk), .rst(rst), .start(start), .busy(busy8), .done(done8),
      .wr_en(wen8), .wr_ready(ready), .wr_addr(addr8), .wr_data(data8));
   card_deal_generator #(.N_PAIRS(2)) u2 (
      .clk(clk), .rst(rst), .start(start), .busy(busy2), .done(done2),
      .wr_en(wen2), .wr_ready(ready), .wr_addr(addr2), .wr_data(data2));

   logic [2:0]  wen_v, busy_v, done_v;
   logic [4:0]  addr_v [3];
   logic [13:0] data_v [3];
   assign wen_v  = {wen2, wen8, wen6};
   assign busy_v = {busy2, busy8, busy6};
   assign done_v = {done2, done8, done6};
   assign addr_v[0] = {1'b0, addr6};
   assign addr_v[1] = addr8;
   assign addr_v[2] = {1'b0, addr2};
   assign data_v[0] = data6;
   assign data_v[1] = data8;
   assign data_v[2] = data2;

   localparam int NP [3] = '{6, 8, 2};
   localparam logic [11:0] PAL [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'h0FF,
                                       12'hF0F, 12'hFF0, 12'hFFF, 12'h0AA};

   int checks = 0;
   int errors = 0;

   // Model state per instance
   int acc [3];
   int deal_cnt [3];
   int wcount [3];
   int first_addr [3];
   int last_addr [3];
   int seq [3][16];
   int last_seq [3][16];
   int ref_seq [3][16];
   bit p_wen [3];
   bit p_rdy [3];
   bit p_last [3];
   bit p_done [3];
   int p_addr [3];
   int p_data [3];

   task automatic chk(input bit ok, input string nm, input int j, input int act, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s inst%0d: got %0h required %0h at %0t", nm, j, act, req, $time);
      end
   endtask

   function automatic int idx_of(input logic [11:0] c);
      for (int p = 0; p < 8; p++) if (PAL[p] == c) return p;
      return -1;
   endfunction

   initial begin
      for (int j = 0; j < 3; j++) begin
         acc[j] = 0; deal_cnt[j] = 0; wcount[j] = 0; first_addr[j] = 0; last_addr[j] = 0;
         p_wen[j] = 0; p_rdy[j] = 0; p_last[j] = 0; p_done[j] = 0; p_addr[j] = 0; p_data[j] = 0;
      end
   end

   // Per-cycle compare against the model, sampled on the falling edge.
   always @(negedge clk) begin
      for (int j = 0; j < 3; j++) begin
         if (!rst) begin
            chk(wen_v[j] == 1'b0, "rst_wr_en", j, int'(wen_v[j]), 0);
            chk(busy_v[j] == 1'b0, "rst_busy", j, int'(busy_v[j]), 0);
            chk(done_v[j] == 1'b0, "rst_done", j, int'(done_v[j]), 0);
            chk(addr_v[j] == 5'd0, "rst_wr_addr", j, int'(addr_v[j]), 0);
            chk(data_v[j] == 14'd0, "rst_wr_data", j, int'(data_v[j]), 0);
            acc[j] = 0; p_wen[j] = 0; p_rdy[j] = 0; p_last[j] = 0; p_done[j] = 0;
         end else begin
            bit this_last;
            int id;
            this_last = 0;
            if (p_wen[j] && !p_rdy[j]) begin
               chk(wen_v[j] == 1'b1, "stall_wr_en", j, int'(wen_v[j]), 1);
               chk(int'(addr_v[j]) == p_addr[j], "stall_wr_addr", j, int'(addr_v[j]), p_addr[j]);
               chk(int'(data_v[j]) == p_data[j], "stall_wr_data", j, int'(data_v[j]), p_data[j]);
            end
            chk(done_v[j] == p_last[j], "done_timing", j, int'(done_v[j]), int'(p_last[j]));
            if (p_done[j]) chk(busy_v[j] == 1'b0, "busy_fall", j, int'(busy_v[j]), 0);
            if (wen_v[j]) begin
               chk(busy_v[j] == 1'b1, "busy_in_write", j, int'(busy_v[j]), 1);
               chk(acc[j] < 2 * NP[j], "extra_write", j, acc[j], 2 * NP[j] - 1);
               chk(int'(addr_v[j]) == 1 + acc[j], "wr_addr", j, int'(addr_v[j]), 1 + acc[j]);
               chk(data_v[j][1:0] == 2'b01, "wr_flags", j, int'(data_v[j][1:0]), 1);
               id = idx_of(data_v[j][13:2]);
               chk(id >= 0 && id < NP[j], "colour", j, int'(data_v[j][13:2]), NP[j]);
               if (ready) begin
                  if (acc[j] < 16) seq[j][acc[j]] = id;
                  if (acc[j] == 0) first_addr[j] = int'(addr_v[j]);
                  last_addr[j] = int'(addr_v[j]);
                  acc[j]++;
                  this_last = (acc[j] == 2 * NP[j]);
               end
            end
            if (done_v[j]) begin
               for (int p = 0; p < 8; p++) begin
                  int n;
                  n = 0;
                  for (int k = 0; k < 2 * NP[j]; k++) if (seq[j][k] == p) n++;
                  chk(n == ((p < NP[j]) ? 2 : 0), "colour_count", j, n, (p < NP[j]) ? 2 : 0);
               end
               wcount[j] = acc[j];
               for (int k = 0; k < 16; k++) last_seq[j][k] = (k < 2 * NP[j]) ? seq[j][k] : 0;
               acc[j] = 0;
               deal_cnt[j]++;
            end
            p_wen[j]  = wen_v[j];
            p_rdy[j]  = ready;
            p_addr[j] = int'(addr_v[j]);
            p_data[j] = int'(data_v[j]);
            p_last[j] = this_last;
            p_done[j] = done_v[j];
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      start = 1'b0;
      cycles(3);
      rst = 1'b1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycles(1);
      start = 1'b0;
   endtask

   task automatic wait_deal(input int j, input int c0);
      int n;
      n = 0;
      while (deal_cnt[j] == c0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk(deal_cnt[j] == c0 + 1, "deal_complete", j, deal_cnt[j], c0 + 1);
   endtask

   function automatic bit same_seq(input int j);
      for (int k = 0; k < 2 * NP[j]; k++) if (last_seq[j][k] != ref_seq[j][k]) return 0;
      return 1;
   endfunction

   task automatic run_deal(input int delay);
      int c0 [3];
      do_reset();
      cycles(delay);
      ready = 1'b1;
      for (int j = 0; j < 3; j++) c0[j] = deal_cnt[j];
      pulse_start();
      for (int j = 0; j < 3; j++) wait_deal(j, c0[j]);
   endtask

   initial begin
      int c0;
      int n;
      int extra;
      bit held;

      // Basic deal with literal expectations on counts and address range
      run_deal(37);
      chk(first_addr[0] == 1, "first_addr6", 0, first_addr[0], 1);
      chk(last_addr[0] == 12, "last_addr6", 0, last_addr[0], 12);
      chk(wcount[0] == 12, "writes6", 0, wcount[0], 12);
      chk(last_addr[1] == 16, "last_addr8", 1, last_addr[1], 16);
      chk(wcount[1] == 16, "writes8", 1, wcount[1], 16);
      chk(last_addr[2] == 4, "last_addr2", 2, last_addr[2], 4);
      chk(wcount[2] == 4, "writes2", 2, wcount[2], 4);
      for (int j = 0; j < 3; j++)
         for (int k = 0; k < 16; k++) ref_seq[j][k] = last_seq[j][k];

      // Same start timing from reset gives the same order
      run_deal(37);
      for (int j = 0; j < 3; j++) chk(same_seq(j), "determinism", j, 0, 1);

      // One cycle later start gives a different order
      run_deal(38);
      chk(!same_seq(0), "variation", 0, 1, 0);

      // Backpressure: random ready, plus a 10-cycle stall on card 5
      do_reset();
      cycles(37);
      ready = 1'b1;
      c0 = deal_cnt[0];
      pulse_start();
      held = 0;
      n = 0;
      while ((deal_cnt[0] == c0 || wen8 || busy8 || busy2) && n < 2000) begin
         if (!held && wen6 && addr6 == 4'd6) begin
            ready = 1'b0;
            cycles(10);
            held = 1;
         end else begin
            ready = 1'($urandom_range(0, 1));
            cycles(1);
         end
         n++;
      end
      ready = 1'b1;
      chk(held, "stall_card5_seen", 0, int'(held), 1);
      chk(deal_cnt[0] == c0 + 1, "bp_deal_complete", 0, deal_cnt[0], c0 + 1);
      for (int j = 0; j < 3; j++) chk(same_seq(j), "bp_same_colours", j, 0, 1);

      // Start while busy: during SHUFFLE, WRITE and the DONE cycle
      do_reset();
      cycles(37);
      ready = 1'b1;
      c0 = deal_cnt[0];
      pulse_start();
      cycles(2);
      pulse_start();
      n = 0;
      while (!wen6 && n < 500) begin cycles(1); n++; end
      chk(wen6, "reach_write", 0, int'(wen6), 1);
      pulse_start();
      n = 0;
      while (!done6 && n < 500) begin @(negedge clk); n++; end
      chk(done6, "reach_done", 0, int'(done6), 1);
      start = 1'b1;
      cycles(1);
      start = 1'b0;
      extra = 0;
      for (int t = 0; t < 80; t++) begin
         if (wen6 || busy6) extra++;
         cycles(1);
      end
      chk(extra == 0, "no_restart", 0, extra, 0);
      chk(deal_cnt[0] == c0 + 1, "single_deal", 0, deal_cnt[0], c0 + 1);
      chk(same_seq(0), "busy_same_colours", 0, 0, 1);

      // Asynchronous reset in the middle of writing card 7
      do_reset();
      cycles(37);
      ready = 1'b1;
      pulse_start();
      n = 0;
      while (!(wen6 && addr6 == 4'd8) && n < 500) begin cycles(1); n++; end
      chk(wen6 && addr6 == 4'd8, "reach_card7", 0, int'(addr6), 8);
      #2 rst = 1'b0;
      #1;
      chk(wen6 == 1'b0, "async_wr_en", 0, int'(wen6), 0);
      chk(busy6 == 1'b0, "async_busy", 0, int'(busy6), 0);
      chk(done6 == 1'b0, "async_done", 0, int'(done6), 0);
      cycles(1);
      rst = 1'b1;
      cycles(5);
      c0 = deal_cnt[0];
      pulse_start();
      wait_deal(0, c0);
      chk(first_addr[0] == 1, "post_rst_first_addr", 0, first_addr[0], 1);
      chk(wcount[0] == 12, "post_rst_writes", 0, wcount[0], 12);

      cycles(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/card_deal_generator.md
Name: card_deal_generator

Overview:
- Parametrised successor to the fixed-layout colour generator.
- On request, deals 2*N_PAIRS cards, each holding a palette colour, in a random order. The order comes from a Fisher-Yates shuffle driven by a free-running LFSR.
- Writes one card word per slot into the card register file, with ready/valid backpressure.
- Sits between the game control FSM (start/done) and the card regfile write port.

Parameters:
- N_PAIRS, 6, number of colour pairs; legal range 2..8; N_CARDS = 2*N_PAIRS.
- ADDR_W, 4, regfile address width; must satisfy BASE_ADDR + N_CARDS - 1 < 2^ADDR_W.
- BASE_ADDR, 1, regfile address of card 0; address 0 is reserved for game variables.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  deal request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last card write is accepted.
- wr_en  out  1  write valid to regfile.
- wr_ready  in  1  regfile accepts the write this cycle.
- wr_addr  out  ADDR_W  card address, BASE_ADDR + slot index.
- wr_data  out  14  card word: [13:2] colour RGB444 (R is MSB); [1] discovered = 0; [0] active = 1.

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-low.
- Reset (rst low, any time, including mid-deal):
  - state = IDLE; busy = 0; done = 0; wr_en = 0; wr_addr = 0; wr_data = 0.
  - lfsr = LFSR_SEED.
  - Slot array and counters are cleared; no partial write is completed.
- LFSR:
  - 16-bit Galois, taps 16'hB400, shifts right every cycle in every state, never reset except by rst.
  - Entropy comes from how many cycles elapse before start.
- Palette: index 0..7 = F00, 0F0, 00F, 0FF, F0F, FF0, FFF, 0AA.
- Slot array: perm[0..N_CARDS-1], 3 bits each.
- IDLE:
  - On start = 1, go to INIT.
  - start in any other state is ignored; no queuing.
- INIT (1 cycle):
  - perm[k] = k>>1 for all k.
  - i = N_CARDS-1.
  - Go to SHUFFLE.
- SHUFFLE (one draw per cycle):
  - mask = smallest 2^m - 1 that is >= i; r = lfsr[3:0] & mask.
  - If r <= i: swap perm[i] and perm[r] (r == i is a no-op), then decrement i.
  - If r > i: reject and retry next cycle.
  - When a swap is accepted with i == 1, go to WRITE with k = 0.
  - Cycle count is variable; the bench must not depend on it.
- WRITE:
  - wr_en = 1, wr_addr = BASE_ADDR + k, wr_data = {palette[perm[k]], 2'b01}.
  - Outputs are held stable while wr_ready = 0.
  - On wr_en && wr_ready: k increments. If k was N_CARDS-1, go to DONE with wr_en = 0 next cycle.
  - Exactly one accepted write per slot. Addresses are strictly ascending with no gaps.
- DONE (1 cycle):
  - done = 1, busy = 1.
  - Next cycle: IDLE, busy = 0.
  - A start in the DONE cycle is ignored.
  - A start in the following IDLE cycle begins a new deal.
- Outputs are registered. done, busy and wr_* change only on clk edges, apart from the asynchronous reset clear.
- Invariant at done: over the N_CARDS writes, each palette index 0..N_PAIRS-1 appears exactly twice, and no other index appears.

Test Plan:
- Basic deal:
  - Stimulus: N_PAIRS=6; release rst; wait 37 cycles; pulse start; wr_ready tied 1.
  - Required: exactly 12 writes to addresses 1..12 in order; each of F00, 0F0, 00F, 0FF, F0F, FF0 appears twice; wr_data[1:0] = 2'b01 on every write.
  - Required: done pulses once, one cycle after the 12th acceptance; busy falls the next cycle.
- Determinism and variation:
  - Repeat the basic deal from reset with identical start timing: the colour sequence is bit-identical.
  - Delay start by 1 cycle: the sequence differs (check for seed 16'hACE1).
- Backpressure:
  - Stimulus: wr_ready toggled pseudo-randomly, including held low 10 cycles on card 5.
  - Required: wr_addr and wr_data stable while stalled; still exactly 12 accepted writes; same colours as the unstalled run with identical start timing.
- Start while busy:
  - Stimulus: pulse start during SHUFFLE, during WRITE, and in the DONE cycle.
  - Required: no restart and no extra writes; the deal completes normally.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously (between edges) during WRITE at card 7.
  - Required: wr_en, busy and done drop to 0 immediately.
  - Required: after release and a new start, a full 12-card deal starts at address 1.
- Parameter sweep:
  - N_PAIRS=8, ADDR_W=5: 16 writes to addresses 1..16, all 8 palette colours twice each.
  - N_PAIRS=2: 4 writes; done follows correctly.
